// File: rtl/piso_tx_sched.sv
// Round-robin scheduler sharing one PISO shift register among N_REQ producers:
// one load cycle, WIDTH shift cycles flagged by frame_valid, then zero-loaded gap cycles.
module piso_tx_sched #(
    parameter  int N_REQ      = 2,
    parameter  int WIDTH      = 4,
    parameter  int GAP_CYCLES = 1,
    localparam int IDW        = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ack,
    output logic [WIDTH-1:0]       piso_d,
    output logic                   piso_sl,
    output logic                   frame_valid,
    output logic [IDW-1:0]         frame_id,
    output logic                   busy
);

    localparam int CNT_MAX = (WIDTH > GAP_CYCLES) ? WIDTH : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0]  SHIFT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  GAP_INIT   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [IDW-1:0] LAST_RST   = IDW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_q, last_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             found;
    logic [IDW-1:0]   win, cand;
    logic [WIDTH-1:0] win_word;
    logic [N_REQ-1:0] ack_d;
    logic [WIDTH-1:0] d_d;
    logic             sl_d, fv_d;
    logic [IDW-1:0]   fid_d;

    // Rotating priority: the requester after the last winner is scanned first.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        cand     = '0;
        win_word = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = IDW'((int'(last_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        for (int i = 0; i < N_REQ; i++) begin
            if (IDW'(i) == win) win_word = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        ack_d   = '0;
        d_d     = '0;
        sl_d    = 1'b0;
        fv_d    = 1'b0;
        fid_d   = '0;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = LOAD;
                    last_d  = win;
                    ack_d   = N_REQ'(1) << win;
                    d_d     = win_word;
                end
            end
            LOAD: begin
                state_d = SHIFT;
                cnt_d   = SHIFT_INIT;
                sl_d    = 1'b1;
                fv_d    = 1'b1;
                fid_d   = last_q;
            end
            SHIFT: begin
                if (cnt_q == '0) begin
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_INIT;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    sl_d  = 1'b1;
                    fv_d  = 1'b1;
                    fid_d = last_q;
                end
            end
            GAP: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= LAST_RST;
            cnt_q       <= '0;
            req_ack     <= '0;
            piso_d      <= '0;
            piso_sl     <= 1'b0;
            frame_valid <= 1'b0;
            frame_id    <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            req_ack     <= ack_d;
            piso_d      <= d_d;
            piso_sl     <= sl_d;
            frame_valid <= fv_d;
            frame_id    <= fid_d;
            busy        <= (state_d != IDLE);
        end
    end

endmodule
